alu_writeback: RTL and testbench

- Writeback stage directly downstream of the ALU.
- Accepts the ALU result pair (Y1, Y2) with destination addresses through a valid/ready handshake.
- Serialises the results onto the register file's single write port.
- Dual results (DOUBLE precision, or two-lane forms) take two write cycles; single results take one.

---
 rtl/alu_writeback.sv | 123 ++++++++++++
 tb/tb_alu_writeback.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// Writeback stage: serialises the ALU result pair (y1, y2) onto the single register-file write port.
// Optional forwarding of the pending second result is enabled with the ALU_WB_FWD_EN macro.
module alu_writeback #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_y1,
   input  logic [DATA_W-1:0]     in_y2,
   input  logic [REG_ADDR_W-1:0] in_rd1,
   input  logic [REG_ADDR_W-1:0] in_rd2,
   input  logic [1:0]            in_mask,
   output logic                  wb_en,
   output logic [REG_ADDR_W-1:0] wb_addr,
   output logic [DATA_W-1:0]     wb_data,
   output logic                  busy
`ifdef ALU_WB_FWD_EN
   ,
   output logic                  fwd_valid,
   output logic [REG_ADDR_W-1:0] fwd_addr,
   output logic [DATA_W-1:0]     fwd_data
`endif
);

   typedef enum logic [1:0] {IDLE, WR_A, WR_B} state_e;

   state_e                  state_q, state_d;
   logic [DATA_W-1:0]       y1_q, y1_d, y2_q, y2_d;
   logic [REG_ADDR_W-1:0]   rd1_q, rd1_d, rd2_q, rd2_d;
   logic [1:0]              mask_q, mask_d;
   logic                    wb_en_q, wb_en_d;
   logic [REG_ADDR_W-1:0]   wb_addr_q, wb_addr_d;
   logic [DATA_W-1:0]       wb_data_q, wb_data_d;
   logic                    final_wr;
   logic                    accept;

   assign final_wr = (state_q == WR_B) || ((state_q == WR_A) && !mask_q[1]);
   assign in_ready = rst_n && ((state_q == IDLE) || final_wr);
   assign accept   = in_valid && in_ready;

   // NOTE: every signal is given a default before the case so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      y1_d      = y1_q;
      y2_d      = y2_q;
      rd1_d     = rd1_q;
      rd2_d     = rd2_q;
      mask_d    = mask_q;
      wb_en_d   = 1'b0;
      wb_addr_d = wb_addr_q;
      wb_data_d = wb_data_q;

      if (accept) begin
         y1_d   = in_y1;
         y2_d   = in_y2;
         rd1_d  = in_rd1;
         rd2_d  = in_rd2;
         mask_d = in_mask;
         if (in_mask[0])      state_d = WR_A;
         else if (in_mask[1]) state_d = WR_B;
         else                 state_d = IDLE;
      end else if ((state_q == WR_A) && mask_q[1]) begin
         state_d = WR_B;
      end else if (final_wr) begin
         state_d = IDLE;
      end

      // Write port is registered from the next state, so wb_* never sees in_* combinationally.
      case (state_d)
         WR_A: begin
            wb_en_d   = (rd1_d != '0);
            wb_addr_d = rd1_d;
            wb_data_d = y1_d;
         end
         WR_B: begin
            wb_en_d   = (rd2_d != '0);
            wb_addr_d = rd2_d;
            wb_data_d = y2_d;
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         y1_q      <= '0;
         y2_q      <= '0;
         rd1_q     <= '0;
         rd2_q     <= '0;
         mask_q    <= '0;
         wb_en_q   <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
      end else begin
         state_q   <= state_d;
         y1_q      <= y1_d;
         y2_q      <= y2_d;
         rd1_q     <= rd1_d;
         rd2_q     <= rd2_d;
         mask_q    <= mask_d;
         wb_en_q   <= wb_en_d;
         wb_addr_q <= wb_addr_d;
         wb_data_q <= wb_data_d;
      end
   end

   assign wb_en   = wb_en_q;
   assign wb_addr = wb_addr_q;
   assign wb_data = wb_data_q;
   assign busy    = (state_q != IDLE);

`ifdef ALU_WB_FWD_EN
   assign fwd_valid = (state_q == WR_A) && mask_q[1] && (rd2_q != '0);
   assign fwd_addr  = rd2_q;
   assign fwd_data  = y2_q;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Directed scoreboard bench for alu_writeback; expected writes are queued at stimulus time.
// Forwarding checks are compiled in when ALU_WB_FWD_EN is defined.
module tb_alu_writeback;

   localparam int DW = 32;
   localparam int AW = 5;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_y1, in_y2;
   logic [AW-1:0] in_rd1, in_rd2;
   logic [1:0]    in_mask;
   logic          wb_en;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic          busy;
`ifdef ALU_WB_FWD_EN
   logic          fwd_valid;
   logic [AW-1:0] fwd_addr;
   logic [DW-1:0] fwd_data;
`endif

   int  n_cmp = 0;
   int  n_err = 0;
   wr_t exp_q[$];

   alu_writeback #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_y1    (in_y1),
      .in_y2    (in_y2),
      .in_rd1   (in_rd1),
      .in_rd2   (in_rd2),
      .in_mask  (in_mask),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .busy     (busy)
`ifdef ALU_WB_FWD_EN
      ,
      .fwd_valid(fwd_valid),
      .fwd_addr (fwd_addr),
      .fwd_data (fwd_data)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle, sample 1ns after the edge and score any register-file write.
   task automatic tick();
      wr_t w;
      @(posedge clk);
      #1;
      if (wb_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write_addr", {59'd0, wb_addr}, 64'h0bad);
         end else begin
            w = exp_q.pop_front();
            check("wb_addr", {59'd0, wb_addr}, {59'd0, w.addr});
            check("wb_data", {32'd0, wb_data}, {32'd0, w.data});
         end
      end
   endtask

   task automatic send(input logic [DW-1:0] y1, input logic [DW-1:0] y2,
                       input logic [AW-1:0] rd1, input logic [AW-1:0] rd2, input logic [1:0] mask);
      wr_t w;
      in_valid = 1'b1;
      in_y1 = y1; in_y2 = y2; in_rd1 = rd1; in_rd2 = rd2; in_mask = mask;
      if (mask[0] && rd1 != 0) begin w.addr = rd1; w.data = y1; exp_q.push_back(w); end
      if (mask[1] && rd2 != 0) begin w.addr = rd2; w.data = y2; exp_q.push_back(w); end
   endtask

   task automatic idle_in();
      in_valid = 1'b0;
      in_y1 = 'x; in_y2 = 'x; in_rd1 = 'x; in_rd2 = 'x; in_mask = 'x;
   endtask

   initial begin
      wr_t w;
      // Reset held with in_valid high
      rst_n = 1'b0;
      in_valid = 1'b1;
      in_y1 = 32'h1; in_y2 = 32'h2; in_rd1 = 5'd1; in_rd2 = 5'd2; in_mask = 2'b11;
      #22;
      check("rst_in_ready", {63'd0, in_ready}, 64'd0);
      check("rst_wb_en",    {63'd0, wb_en},    64'd0);
      check("rst_busy",     {63'd0, busy},     64'd0);
      check("rst_wb_addr",  {59'd0, wb_addr},  64'd0);
      check("rst_wb_data",  {32'd0, wb_data},  64'd0);
      idle_in();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

      // Single write
      send(32'h0000_0005, 32'h0, 5'd3, 5'd0, 2'b01);
      tick();
      check("single_wb_en",    {63'd0, wb_en},    64'd1);
      check("single_in_ready", {63'd0, in_ready}, 64'd1);
      idle_in();
      tick();
      check("single_idle_wb_en", {63'd0, wb_en}, 64'd0);
      check("single_idle_busy",  {63'd0, busy},  64'd0);
      check("idle_holds_addr",   {59'd0, wb_addr}, 64'd3);

      // Double write followed by a queued single entry
      send(32'hDEAD_BEEF, 32'h1234_5678, 5'd4, 5'd5, 2'b11);
      tick();
      check("dbl_c1_wb_en",    {63'd0, wb_en},    64'd1);
      check("dbl_c1_in_ready", {63'd0, in_ready}, 64'd0);
      send(32'h0000_0077, 32'h0, 5'd9, 5'd0, 2'b01);
      tick();
      check("dbl_c2_wb_en",    {63'd0, wb_en},    64'd1);
      check("dbl_c2_in_ready", {63'd0, in_ready}, 64'd1);
      tick();
      idle_in();
      check("dbl_c3_wb_en",   {63'd0, wb_en},   64'd1);
      check("dbl_c3_wb_addr", {59'd0, wb_addr}, 64'd9);
      tick();
      check("dbl_idle_wb_en", {63'd0, wb_en}, 64'd0);

      // r0 suppression
      send(32'h0000_0001, 32'h0000_0009, 5'd0, 5'd7, 2'b11);
      tick();
      idle_in();
      check("r0_c1_wb_en", {63'd0, wb_en}, 64'd0);
      check("r0_c1_busy",  {63'd0, busy},  64'd1);
      tick();
      check("r0_c2_wb_en", {63'd0, wb_en}, 64'd1);
      tick();

      // Mask 00 discard
      send(32'hFFFF_FFFF, 32'hEEEE_EEEE, 5'd12, 5'd13, 2'b00);
      tick();
      idle_in();
      check("m00_wb_en",    {63'd0, wb_en},    64'd0);
      check("m00_in_ready", {63'd0, in_ready}, 64'd1);
      check("m00_busy",     {63'd0, busy},     64'd0);

      // Same destination: Y2 lands last
      send(32'h0000_0001, 32'h0000_0002, 5'd2, 5'd2, 2'b11);
      tick();
      idle_in();
      check("same_c1_data", {32'd0, wb_data}, 64'd1);
      tick();
      check("same_c2_data", {32'd0, wb_data}, 64'd2);
      tick();

      // Mask 10: only Y2, single cycle
      send(32'h0000_0010, 32'h0000_0020, 5'd14, 5'd15, 2'b10);
      tick();
      idle_in();
      check("m10_in_ready", {63'd0, in_ready}, 64'd1);
      tick();
      check("m10_idle_busy", {63'd0, busy}, 64'd0);

      // Forwarding window
      send(32'h0000_0010, 32'h0000_00AA, 5'd8, 5'd6, 2'b11);
      tick();
      idle_in();
`ifdef ALU_WB_FWD_EN
      check("fwd_valid_wra", {63'd0, fwd_valid}, 64'd1);
      check("fwd_addr",      {59'd0, fwd_addr},  64'd6);
      check("fwd_data",      {32'd0, fwd_data},  64'h00AA);
`endif
      tick();
`ifdef ALU_WB_FWD_EN
      check("fwd_valid_wrb", {63'd0, fwd_valid}, 64'd0);
`endif
      tick();

      // Reset in WR_A of a dual entry: second write must never appear
      send(32'h0000_0033, 32'h0000_0044, 5'd10, 5'd11, 2'b11);
      void'(exp_q.pop_back());
      tick();
      idle_in();
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_wb_en", {63'd0, wb_en}, 64'd0);
      check("midrst_busy",  {63'd0, busy},  64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("midrst_rel_wb_en", {63'd0, wb_en}, 64'd0);
      tick();
      tick();

      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
